// File: rtl/fwd_mux_pipe.sv
// Saturating-select operand mux with a one-entry valid/ready register stage.
// Define FWD_MUX_STATS_EN to build per-source transfer counters.
module fwd_mux_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = $clog2(NUM_SRC),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*WIDTH-1:0] d_flat,
    input  logic [SEL_W-1:0]         s,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [WIDTH-1:0]         y,
    output logic [SEL_W-1:0]         sel_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     stats_clr,
    output logic [NUM_SRC*CNT_W-1:0] stats_cnt_flat
);

    localparam logic [SEL_W-1:0] LastSrc = SEL_W'(NUM_SRC - 1);

    logic [SEL_W-1:0] eff;
    logic [WIDTH-1:0] d_sel;
    logic             capture;
    logic             xfer;

    // Any code at or beyond the last source selects the last source.
    always_comb begin
        eff = (s >= LastSrc) ? LastSrc : s;
    end

    always_comb begin
        d_sel = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eff == SEL_W'(i)) begin
                d_sel = d_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign xfer     = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y         <= '0;
            sel_q     <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            // y and sel_q intentionally keep their last value.
            out_valid <= 1'b0;
        end else if (capture) begin
            y         <= d_sel;
            sel_q     <= eff;
            out_valid <= 1'b1;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

`ifdef FWD_MUX_STATS_EN
    logic [CNT_W-1:0] cnt [NUM_SRC];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= '0;
            end
        end else if (stats_clr) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= '0;
            end
        end else if (xfer) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (sel_q == SEL_W'(i) && cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        stats_cnt_flat = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            stats_cnt_flat[i*CNT_W +: CNT_W] = cnt[i];
        end
    end
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign stats_cnt_flat   = '0;
`endif

endmodule

// File: tb/tb_fwd_mux_pipe.sv
// Scoreboard bench for fwd_mux_pipe: main 4-source stage plus 3- and 2-source decode checks.
module tb_fwd_mux_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] d_flat;
    logic [1:0]   s;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [31:0]  y;
    logic [1:0]   sel_q;
    logic         out_valid;
    logic         out_ready;
    logic         stats_clr;
    logic [15:0]  stats_cnt_flat;

    // Auxiliary instances for saturating decode with other source counts.
    logic         aux_valid;
    logic         aux_ready;
    logic         aux_flush;
    logic         aux_clr;
    logic [95:0]  d3_flat;
    logic [1:0]   s3;
    logic         in_ready3;
    logic [31:0]  y3;
    logic [1:0]   sel3;
    logic         out_valid3;
    logic [11:0]  cnt3_flat;
    logic [63:0]  d2_flat;
    logic         s2;
    logic         in_ready2;
    logic [31:0]  y2;
    logic         sel2;
    logic         out_valid2;
    logic [7:0]   cnt2_flat;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] y;
        logic [1:0]  sel;
    } exp_t;

    exp_t        q[$];
    logic [31:0] last_y;
    logic [1:0]  last_sel;
    int          exp_cnt[4];

    always #5 clk = ~clk;

    fwd_mux_pipe #(.WIDTH(32), .NUM_SRC(4), .CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .d_flat         (d_flat),
        .s              (s),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .flush          (flush),
        .y              (y),
        .sel_q          (sel_q),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .stats_clr      (stats_clr),
        .stats_cnt_flat (stats_cnt_flat)
    );

    fwd_mux_pipe #(.WIDTH(32), .NUM_SRC(3), .CNT_W(4)) dut3 (
        .clk            (clk),
        .reset          (reset),
        .d_flat         (d3_flat),
        .s              (s3),
        .in_valid       (aux_valid),
        .in_ready       (in_ready3),
        .flush          (aux_flush),
        .y              (y3),
        .sel_q          (sel3),
        .out_valid      (out_valid3),
        .out_ready      (aux_ready),
        .stats_clr      (aux_clr),
        .stats_cnt_flat (cnt3_flat)
    );

    fwd_mux_pipe #(.WIDTH(32), .NUM_SRC(2), .CNT_W(4)) dut2 (
        .clk            (clk),
        .reset          (reset),
        .d_flat         (d2_flat),
        .s              (s2),
        .in_valid       (aux_valid),
        .in_ready       (in_ready2),
        .flush          (aux_flush),
        .y              (y2),
        .sel_q          (sel2),
        .out_valid      (out_valid2),
        .out_ready      (aux_ready),
        .stats_clr      (aux_clr),
        .stats_cnt_flat (cnt2_flat)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_stats();
        logic [15:0] f;
        f = '0;
`ifdef FWD_MUX_STATS_EN
        for (int i = 0; i < 4; i++) begin
            f[i*4 +: 4] = 4'(exp_cnt[i]);
        end
`endif
        return f;
    endfunction

    task automatic model_reset();
        q.delete();
        last_y   = '0;
        last_sel = '0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    endtask

    // One cycle: drive at negedge, check registered state, then advance the model.
    task automatic step(input logic iv, input logic [1:0] sv, input logic [127:0] df,
                        input logic ordy, input logic fl, input logic clr);
        logic exp_valid;
        @(negedge clk);
        in_valid  = iv;
        s         = sv;
        d_flat    = df;
        out_ready = ordy;
        flush     = fl;
        stats_clr = clr;
        #1;
        exp_valid = (q.size() != 0);
        check("out_valid", out_valid, exp_valid);
        check("in_ready", in_ready, !exp_valid || ordy);
        check("y", y, exp_valid ? q[0].y : last_y);
        check("sel_q", sel_q, exp_valid ? q[0].sel : last_sel);
        check("stats", stats_cnt_flat, exp_stats());
        if (exp_valid && ordy) begin
            if (exp_cnt[q[0].sel] != 15) exp_cnt[q[0].sel]++;
            void'(q.pop_front());
        end
        if (clr) begin
            for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        end
        if (fl) begin
            q.delete();
        end else if (iv && (!exp_valid || ordy)) begin
            exp_t e;
            e.y   = df[sv*32 +: 32];
            e.sel = sv;
            q.push_back(e);
            last_y   = e.y;
            last_sel = e.sel;
        end
    endtask

    function automatic logic [127:0] rand_d();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    localparam logic [127:0] DBase = {32'h44, 32'h33, 32'h22, 32'h11};

    initial begin
        reset     = 1'b1;
        d_flat    = DBase;
        s         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        stats_clr = 1'b0;
        aux_valid = 1'b1;
        aux_ready = 1'b1;
        aux_flush = 1'b0;
        aux_clr   = 1'b0;
        d3_flat   = {32'hAAAA_5555, 32'h0000_BBBB, 32'h0000_CCCC};
        s3        = 2'd3;
        d2_flat   = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
        s2        = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_y", y, 32'h0);
        check("rst_sel", sel_q, 2'd0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_stats", stats_cnt_flat, 16'h0);
        reset = 1'b0;

        // Basic select then asynchronous reset while holding an operand.
        step(1'b1, 2'd2, DBase, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, DBase, 1'b0, 1'b0, 1'b0);
        check("basic_y", y, 32'h33);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_y", y, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Stall: capture 0x22, hold for three cycles under changing inputs, then drain+capture.
        step(1'b1, 2'd1, DBase, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 2'(i), rand_d(), 1'b0, 1'b0, 1'b0);
        check("stall_y", y, 32'h22);
        step(1'b1, 2'd3, DBase, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, DBase, 1'b1, 1'b0, 1'b0);

        // Back-to-back streaming of eight operands.
        for (int i = 0; i < 8; i++) step(1'b1, 2'(i), rand_d(), 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, DBase, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, DBase, 1'b1, 1'b0, 1'b0);

        // Flush while holding and with a capture request.
        step(1'b1, 2'd0, DBase, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, DBase, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd2, DBase, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, DBase, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, DBase, 1'b1, 1'b0, 1'b0);

        // Counter saturation from source 1, then clear during a transfer.
        for (int i = 0; i < 20; i++) step(1'b1, 2'd1, rand_d(), 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd1, DBase, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'd0, DBase, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, DBase, 1'b1, 1'b0, 1'b0);

        // Saturating decode on the 3- and 2-source instances.
        @(negedge clk);
        s3 = 2'd3;
        s2 = 1'b1;
        @(negedge clk);
        check("sat3_y", y3, 32'hAAAA_5555);
        check("sat3_sel", sel3, 2'd2);
        check("sat3_valid", out_valid3, 1'b1);
        check("sat2_y1", y2, 32'hD1D1_D1D1);
        check("sat2_ready", in_ready2, 1'b1);
        s3 = 2'd1;
        s2 = 1'b0;
        @(negedge clk);
        check("sat3_y1", y3, 32'h0000_BBBB);
        check("sat3_ready", in_ready3, 1'b1);
        check("sat2_y0", y2, 32'hD0D0_D0D0);
        check("sat2_sel", sel2, 1'b0);
        check("sat2_valid", out_valid2, 1'b1);
        check("aux_stats", {cnt3_flat, cnt2_flat} & 20'h0, 20'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
